// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector hit statistics block.
// Holds the report bundle, slot state enum and position-width helper.
package seq_det_pkg;

  // Report fields are sized for the widest legal configuration;
  // each instance uses only the low CNT_W / $clog2(WIN_LEN) bits.
  localparam int SEQ_CNT_MAX_W = 16;
  localparam int SEQ_POS_MAX_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_e;

  typedef struct packed {
    logic [SEQ_CNT_MAX_W-1:0] count;
    logic [SEQ_POS_MAX_W-1:0] first;
    logic                     lost;
`ifdef SEQ_HIT_SAT_FLAG_EN
    logic                     sat;
`endif
  } seq_rpt_t;

  function automatic int seq_pos_w(input int win_len);
    return (win_len < 2) ? 1 : $clog2(win_len);
  endfunction

endpackage

// File: rtl/seq_rpt_slot.sv
// One-entry valid/ready report holding register.
// Ports: clk, rst, load, din, ready -> valid, dout, drop.
module seq_rpt_slot
  import seq_det_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  seq_rpt_t din,
  input  logic     ready,
  output logic     valid,
  output seq_rpt_t dout,
  output logic     drop
);

  slot_st_e state_q;
  slot_st_e state_d;
  logic     upd;
  seq_rpt_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (upd) begin
        data_q <= din;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    upd     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          upd     = 1'b1;
        end
      end
      SLOT_FULL: begin
        // A load that meets an accept replaces the report in place;
        // without the accept the new report is thrown away.
        if (load) begin
          if (ready) begin
            upd = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign valid = (state_q == SLOT_FULL);
  assign dout  = data_q;

endmodule

// File: rtl/seq_hit_window.sv
// Windowed hit counter for sequence detectors; one report per window.
// Ports: clk, rst, bit_vld, hit, rpt_ready -> rpt_valid, rpt_count,
// rpt_first, rpt_lost, rpt_sat (only with SEQ_HIT_SAT_FLAG_EN).
module seq_hit_window
  import seq_det_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_vld,
  input  logic                          hit,
  output logic                          rpt_valid,
  input  logic                          rpt_ready,
  output logic [CNT_W-1:0]              rpt_count,
  output logic [seq_pos_w(WIN_LEN)-1:0] rpt_first,
  output logic                          rpt_lost
`ifdef SEQ_HIT_SAT_FLAG_EN
  ,
  output logic                          rpt_sat
`endif
);

  localparam int              PW       = seq_pos_w(WIN_LEN);
  localparam logic [PW-1:0]   POS_LAST = PW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic [PW-1:0]    pos;
  logic [CNT_W-1:0] acc;
  logic [PW-1:0]    first;
  logic             seen;
  logic             lost_pend;

  logic             take;
  logic             close;
  logic [CNT_W-1:0] acc_nx;
  logic [PW-1:0]    first_nx;

  seq_rpt_t         rpt_d;
  seq_rpt_t         rpt_q;
  logic             drop;

  assign take  = bit_vld & hit;
  assign close = bit_vld & (pos == POS_LAST);

  // Next-window values include the current bit, so the closing
  // bit's hit lands in the report built from them.
  always_comb begin
    acc_nx = acc;
    if (take && (acc != ACC_MAX)) begin
      acc_nx = acc + CNT_W'(1);
    end
    first_nx = first;
    if (take && !seen) begin
      first_nx = pos;
    end
  end

`ifdef SEQ_HIT_SAT_FLAG_EN
  logic ovf;
  logic ovf_nx;

  assign ovf_nx = ovf | (take & (acc == ACC_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (bit_vld) begin
      ovf <= close ? 1'b0 : ovf_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pos   <= '0;
      acc   <= '0;
      first <= '0;
      seen  <= 1'b0;
    end else if (bit_vld) begin
      if (close) begin
        pos   <= '0;
        acc   <= '0;
        first <= '0;
        seen  <= 1'b0;
      end else begin
        pos   <= pos + PW'(1);
        acc   <= acc_nx;
        first <= first_nx;
        seen  <= seen | take;
      end
    end
  end

  // Pending-lost rides on the next report that actually enters
  // the slot; a dropped close re-arms it instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_pend <= 1'b0;
    end else if (drop) begin
      lost_pend <= 1'b1;
    end else if (close) begin
      lost_pend <= 1'b0;
    end
  end

  always_comb begin
    rpt_d                  = '0;
    rpt_d.count[CNT_W-1:0] = acc_nx;
    rpt_d.first[PW-1:0]    = first_nx;
    rpt_d.lost             = lost_pend;
`ifdef SEQ_HIT_SAT_FLAG_EN
    rpt_d.sat              = ovf_nx;
`endif
  end

  seq_rpt_slot u_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (close),
    .din   (rpt_d),
    .ready (rpt_ready),
    .valid (rpt_valid),
    .dout  (rpt_q),
    .drop  (drop)
  );

  assign rpt_count = rpt_q.count[CNT_W-1:0];
  assign rpt_first = rpt_q.first[PW-1:0];
  assign rpt_lost  = rpt_q.lost;
`ifdef SEQ_HIT_SAT_FLAG_EN
  assign rpt_sat   = rpt_q.sat;
`endif

  logic unused_rpt;
  assign unused_rpt = ^{rpt_q.count, rpt_q.first};

endmodule

// File: doc/seq_hit_window.md
# seq_hit_window

Downstream consumer of the Mealy/Moore sequence detectors: counts detector hits (`z`) over fixed windows of qualified input bits and emits one report per window over a valid/ready handshake. Sits between the detector output and the status/CSR logic, turning per-bit hit pulses into windowed statistics. A one-entry report slot decouples window closing from a slow consumer. Reports the consumer does not accept in time are dropped and flagged.

## Interface
- `WIN_LEN`, 16: qualified bits per window; legal range 2..65535.
- `CNT_W`, 8: width of the hit counter and `rpt_count`; legal range 1..16.
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `bit_vld` in 1: marks the cycles in which the detector consumed a bit of `x`, so `hit` is meaningful.
- `hit` in 1: detector output `z`; sampled only when `bit_vld`=1.
- `rpt_valid` out 1: report slot holds a report.
- `rpt_ready` in 1: consumer accepts the report.
- `rpt_count` out CNT_W: hits in the reported window, saturating.
- `rpt_first` out $clog2(WIN_LEN): bit index (0-based) of the first hit in the window; 0 when `rpt_count`=0.
- `rpt_lost` out 1: one or more window reports were dropped since the previous accepted report.
- `rpt_sat` out 1: present only with `SEQ_HIT_SAT_FLAG_EN`; the window's count saturated.

## Operation
- Window position `pos` runs 0..WIN_LEN-1 and advances on each `bit_vld`. At WIN_LEN-1 it wraps to 0, which closes the window.
- Accumulator `acc` increments on `bit_vld & hit` and saturates at 2^CNT_W-1.
- `first`/`seen`: on the first `bit_vld & hit` of a window, `first` <= `pos` and `seen` <= 1.
- Close (`bit_vld` and `pos`==WIN_LEN-1):
  - The closing bit's hit is included: the report count is sat(`acc`+`hit`).
  - If the closing bit is the window's first hit, `first` = WIN_LEN-1.
  - `acc`, `seen` and `first` clear for the next window in the same cycle.
- Slot states EMPTY and FULL.
  - EMPTY→FULL on close.
  - FULL→EMPTY on `rpt_ready` with no close.
  - FULL stays FULL on a close coinciding with `rpt_ready`: the new report is loaded and no drop occurs.
  - FULL with a close and no `rpt_ready`: the new report is discarded, the held report is unchanged, and pending-lost is set.
- `rpt_lost` is attached to the next report loaded into the slot; pending-lost clears on that load.
- `hit` with `bit_vld`=0 is ignored.
- Reset values:
  - `rpt_valid`=0, `rpt_count`=0, `rpt_first`=0, `rpt_lost`=0, `rpt_sat`=0.
  - `pos`=0, `acc`=0, pending-lost=0.
- Reset mid-window or with a report pending discards all state. There is no partial report.

## Timing
- Report latency: `rpt_valid` rises the cycle after the closing `bit_vld`.
- While `rpt_valid`=1 and `rpt_ready`=0, all `rpt_*` outputs are held stable.
- Transfer occurs on `rpt_valid & rpt_ready`. `rpt_ready` while EMPTY has no effect.
- Back-to-back closes are impossible, since the minimum window is 2 bits. Full throughput is sustained with `rpt_ready` tied high.
- No combinational path from `rpt_ready` to `rpt_valid`; all outputs come from registers.

## Configuration
- `SEQ_HIT_SAT_FLAG_EN` defined:
  - Port `rpt_sat` exists.
  - It is 1 when the window's unsaturated count exceeded 2^CNT_W-1.
  - It is registered with the report.
- Not defined: the port and its register are absent; counting behaviour is unchanged and still saturates.

## Structure
- Package `seq_det_pkg` holds:
  - the `seq_rpt_t` struct (`count`, `first`, `lost`, and conditionally `sat`);
  - the slot state enum (EMPTY/FULL);
  - the width helper for `$clog2(WIN_LEN)`.
- Sub-module `seq_rpt_slot`: a one-entry valid/ready holding register. It takes a load strobe plus a `seq_rpt_t` and returns `drop`. The top level owns `pos`/`acc`/`first` and the pending-lost flag.

## Test plan
- **Window count:** WIN_LEN=16, `bit_vld` every cycle, hits at positions 2, 7, 15, `rpt_ready`=1. Expect one report one cycle after the bit at pos 15: `rpt_count`=3, `rpt_first`=2, `rpt_lost`=0.
- **Empty window:** no hits over 16 qualified bits. Expect `rpt_count`=0, `rpt_first`=0.
- **Saturation:** CNT_W=2, hits on all 16 bits. Expect `rpt_count`=3, and `rpt_sat`=1 when the macro is defined.
- **Backpressure/drop:** `rpt_ready`=0 for 40 qualified bits. Expect:
  - window-1 report held stable throughout;
  - window-2 dropped;
  - `rpt_ready`=1, then the window-3 report arrives with `rpt_lost`=1 and window-3 counts.
- **Simultaneous close and accept:** `rpt_ready` pulses in the same cycle as a close. Expect `rpt_valid` to stay 1 with the new window's data and `rpt_lost`=0.
- **Qualification and reset:** `hit`=1 with `bit_vld`=0 is not counted. Asserting `rst` at pos 9 with `rpt_valid`=1 gives all outputs 0 next cycle, and the next report covers a full 16 bits after reset.
